// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared state encodings, RV32I opcode constants and the post-EX routing helper
// for the multicycle control FSM.
package mc_ctrl_fsm_pkg;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EX   = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [1:0] {
        EXD_IF  = 2'd0,
        EXD_WB  = 2'd1,
        EXD_MEM = 2'd2
    } ex_dest_e;

    function automatic ex_dest_e ex_dest(input logic [6:0] op);
        ex_dest_e d;
        case (op)
            OP_ARITH, OP_ARITH_IMM, OP_JAL, OP_JALR: d = EXD_WB;
            OP_LOAD, OP_STORE:                       d = EXD_MEM;
            // Branches and unrecognised opcodes both retire straight back to fetch.
            default:                                 d = EXD_IF;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_next_state.sv
// Purely combinational next-state function of the multicycle control FSM.
module mc_next_state
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [2:0] state_i,
    input  logic [6:0] opcode_i,
    input  logic       bcond_i,
    input  logic       is_halt_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    input  logic       ex_last_i,
    input  logic       wait_expired_i,
    output logic [2:0] next_state_o
);

    // The branch outcome only steers the PC mux; both outcomes return to IF.
    logic unused_bcond;
    assign unused_bcond = bcond_i;

    always_comb begin
        next_state_o = state_i;
        case (state_i)
            ST_IF: begin
                if (imem_ready_i)        next_state_o = ST_ID;
                else if (wait_expired_i) next_state_o = ST_HALT;
            end
            ST_ID: begin
                if (opcode_i == OP_ECALL) next_state_o = is_halt_i ? ST_HALT : ST_IF;
                else                      next_state_o = ST_EX;
            end
            ST_EX: begin
                if (ex_last_i) begin
                    case (ex_dest(opcode_i))
                        EXD_WB:  next_state_o = ST_WB;
                        EXD_MEM: next_state_o = ST_MEM;
                        default: next_state_o = ST_IF;
                    endcase
                end
            end
            ST_MEM: begin
                if (dmem_ready_i)        next_state_o = (opcode_i == OP_STORE) ? ST_IF : ST_WB;
                else if (wait_expired_i) next_state_o = ST_HALT;
            end
            ST_WB:   next_state_o = ST_IF;
            ST_HALT: next_state_o = ST_HALT;
            default: next_state_o = ST_IF;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Registered multicycle control FSM for the RV32I core: state register, wait/EX
// counter, sticky timeout flag and the datapath enable decode.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int unsigned EX_LAT  = 1,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       bcond,
    input  logic       is_halt,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic [2:0] state,
    output logic       imem_req,
    output logic       ir_write,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       reg_write,
    output logic       pc_write,
    output logic       halted,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] EX_LAST_CNT  = CNT_W'(EX_LAT - 1);
    // Wraps to all-ones when TIMEOUT is 0, but TMO_EN masks it off in that case.
    localparam logic [CNT_W-1:0] TMO_LAST_CNT = CNT_W'(TIMEOUT - 1);
    localparam logic             TMO_EN       = (TIMEOUT != 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             wait_state;
    logic             ex_last;
    logic             wait_expired;

    assign wait_state   = (state_q == ST_IF) || (state_q == ST_MEM);
    assign ex_last      = (state_q == ST_EX) && (cnt_q == EX_LAST_CNT);
    assign wait_expired = TMO_EN && wait_state && (cnt_q == TMO_LAST_CNT);

    mc_next_state u_next_state (
        .state_i        (state_q),
        .opcode_i       (opcode),
        .bcond_i        (bcond),
        .is_halt_i      (is_halt),
        .imem_ready_i   (imem_ready),
        .dmem_ready_i   (dmem_ready),
        .ex_last_i      (ex_last),
        .wait_expired_i (wait_expired),
        .next_state_o   (state_d)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    // Leaving a wait state for HALT can only be caused by the watchdog.
    assign timeout_d = timeout_q | (wait_expired && (state_d == ST_HALT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IF;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Enables are gated by reset_n so requests drop the moment reset asserts.
    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        if (reset_n) begin
            case (state_q)
                ST_IF: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                ST_ID:  pc_write = (opcode == OP_ECALL) && !is_halt;
                ST_EX:  pc_write = ex_last && (ex_dest(opcode) == EXD_IF);
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STORE);
                    pc_write = dmem_ready && (opcode == OP_STORE);
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == ST_HALT);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: two parameterisations run against a cycle-level
// reference model, plus literal per-cycle expectations for each scenario.
module tb_mc_ctrl_fsm;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ARITH  = 7'b0110011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam int A_EXLAT = 1, A_TMO = 10;
    localparam int B_EXLAT = 3, B_TMO = 0;

    typedef struct packed {
        int         cnt;
        logic [2:0] st;
        logic       to;
    } mst_t;

    logic       clk;
    logic       rn_a, rn_b;
    logic [6:0] op  [2];
    logic       bc  [2];
    logic       hl  [2];
    logic       ird [2];
    logic       drd [2];
    logic [2:0] st  [2];
    logic       imr [2];
    logic       irw [2];
    logic       dmr [2];
    logic       dwe [2];
    logic       rgw [2];
    logic       pcw [2];
    logic       hal [2];
    logic       tmo [2];

    int checks = 0;
    int errors = 0;
    mst_t m_a = '0;
    mst_t m_b = '0;

    mc_ctrl_fsm #(.EX_LAT(A_EXLAT), .CNT_W(8), .TIMEOUT(A_TMO)) dut_a (
        .clk(clk), .reset_n(rn_a), .opcode(op[0]), .bcond(bc[0]), .is_halt(hl[0]),
        .imem_ready(ird[0]), .dmem_ready(drd[0]), .state(st[0]), .imem_req(imr[0]),
        .ir_write(irw[0]), .dmem_req(dmr[0]), .dmem_we(dwe[0]), .reg_write(rgw[0]),
        .pc_write(pcw[0]), .halted(hal[0]), .timeout(tmo[0])
    );

    mc_ctrl_fsm #(.EX_LAT(B_EXLAT), .CNT_W(8), .TIMEOUT(B_TMO)) dut_b (
        .clk(clk), .reset_n(rn_b), .opcode(op[1]), .bcond(bc[1]), .is_halt(hl[1]),
        .imem_ready(ird[1]), .dmem_ready(drd[1]), .state(st[1]), .imem_req(imr[1]),
        .ir_write(irw[1]), .dmem_req(dmr[1]), .dmem_we(dwe[1]), .reg_write(rgw[1]),
        .pc_write(pcw[1]), .halted(hal[1]), .timeout(tmo[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [2:0] after_ex(logic [6:0] o);
        if (o == OP_LOAD || o == OP_STORE) return S_MEM;
        if (o == OP_ARITH || o == OP_ADDI || o == OP_JAL || o == OP_JALR) return S_WB;
        return S_IF;
    endfunction

    function automatic mst_t m_next(mst_t m, int exlat, int tlim, logic [6:0] o,
                                    logic h, logic ir, logic dr);
        mst_t n;
        n = m;
        n.cnt = m.cnt + 1;
        case (m.st)
            S_IF: begin
                if (ir) n.st = S_ID;
                else if (tlim != 0 && m.cnt >= tlim - 1) begin n.st = S_HALT; n.to = 1'b1; end
            end
            S_ID:  n.st = (o == OP_ECALL) ? (h ? S_HALT : S_IF) : S_EX;
            S_EX:  if (m.cnt + 1 >= exlat) n.st = after_ex(o);
            S_MEM: begin
                if (dr) n.st = (o == OP_STORE) ? S_IF : S_WB;
                else if (tlim != 0 && m.cnt >= tlim - 1) begin n.st = S_HALT; n.to = 1'b1; end
            end
            S_WB:  n.st = S_IF;
            default: n.st = m.st;
        endcase
        if (n.st != m.st) n.cnt = 0;
        return n;
    endfunction

    function automatic logic [10:0] m_out(mst_t m, int exlat, logic rstn, logic [6:0] o,
                                          logic h, logic ir, logic dr);
        logic im, iw, dm, dw, rw, pw;
        im = (m.st == S_IF);
        iw = im && ir;
        dm = (m.st == S_MEM);
        dw = dm && (o == OP_STORE);
        rw = (m.st == S_WB);
        pw = (m.st == S_ID && o == OP_ECALL && !h)
           || (m.st == S_EX && m.cnt >= exlat - 1 && after_ex(o) == S_IF)
           || (dm && dr && o == OP_STORE) || rw;
        if (!rstn) {im, iw, dm, dw, rw, pw} = 6'b0;
        return {m.st, im, iw, dm, dw, rw, pw, (m.st == S_HALT), m.to};
    endfunction

    always @(posedge clk or negedge rn_a) begin
        if (!rn_a) m_a <= '0;
        else       m_a <= m_next(m_a, A_EXLAT, A_TMO, op[0], hl[0], ird[0], drd[0]);
    end

    always @(posedge clk or negedge rn_b) begin
        if (!rn_b) m_b <= '0;
        else       m_b <= m_next(m_b, B_EXLAT, B_TMO, op[1], hl[1], ird[1], drd[1]);
    end

    function automatic logic [10:0] act(int k);
        return {st[k], imr[k], irw[k], dmr[k], dwe[k], rgw[k], pcw[k], hal[k], tmo[k]};
    endfunction

    task automatic cmp(string n, logic [10:0] got, logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b expected=%b", n, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        cmp("model_dut_a", act(0), m_out(m_a, A_EXLAT, rn_a, op[0], hl[0], ird[0], drd[0]));
        cmp("model_dut_b", act(1), m_out(m_b, B_EXLAT, rn_b, op[1], hl[1], ird[1], drd[1]));
    end

    // ---------------- directed scenarios ----------------
    task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", n, $time, got, exp);
        end else begin
            $display("ok   %s = %0h", n, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(int k);
        op[k] = '0; bc[k] = 1'b0; hl[k] = 1'b0; ird[k] = 1'b0; drd[k] = 1'b0;
        if (k == 0) rn_a = 1'b0; else rn_b = 1'b0;
        step();
        step();
        if (k == 0) rn_a = 1'b1; else rn_b = 1'b1;
    endtask

    initial begin
        int n_req, n_we;
        logic rw_seen;
        for (int k = 0; k < 2; k++) begin
            op[k] = '0; bc[k] = 1'b0; hl[k] = 1'b0; ird[k] = 1'b0; drd[k] = 1'b0;
        end
        rn_a = 1'b0;
        rn_b = 1'b0;
        smp();
        chk("reset_state", st[0], S_IF);
        chk("reset_imem_req_forced_low", imr[0], 0);
        chk("reset_halted_timeout", {hal[1], tmo[1]}, 0);
        step();

        // ADDI, EX_LAT=1: IF ID EX WB, then IF
        do_reset(0);
        op[0] = OP_ADDI; ird[0] = 1'b1;
        smp(); chk("addi_c1_state", st[0], S_IF); chk("addi_c1_ir_write", irw[0], 1);
        step(); ird[0] = 1'b0;
        smp(); chk("addi_c2_state", st[0], S_ID);
        step(); smp(); chk("addi_c3_state", st[0], S_EX);
        step(); smp(); chk("addi_c4_state", st[0], S_WB);
        chk("addi_c4_reg_pc_write", {rgw[0], pcw[0]}, 2'b11);
        step(); smp(); chk("addi_c5_state", st[0], S_IF);
        step();

        // LOAD with 3 data wait cycles: 8 cycles total
        do_reset(0);
        op[0] = OP_LOAD; ird[0] = 1'b1; n_req = 0; n_we = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) ird[0] = 1'b0;
            drd[0] = (c == 7);
            smp();
            if (dmr[0]) n_req++;
            if (dwe[0]) n_we++;
            if (c == 8) chk("load_c8_state", st[0], S_WB);
            step();
        end
        drd[0] = 1'b0;
        chk("load_dmem_req_cycles", n_req, 4);
        chk("load_dmem_we_cycles", n_we, 0);
        smp(); chk("load_c9_state", st[0], S_IF);
        step();

        // STORE, data ready held high the whole time (ignored outside MEM): 4 cycles
        do_reset(0);
        op[0] = OP_STORE; ird[0] = 1'b1; drd[0] = 1'b1;
        smp(); step(); ird[0] = 1'b0;
        smp(); chk("store_c2_state", st[0], S_ID);
        step(); smp(); step(); smp();
        chk("store_c4_mem_we_pc", {st[0], dmr[0], dwe[0], pcw[0]}, {S_MEM, 3'b111});
        step(); smp(); chk("store_c5_state", st[0], S_IF);
        drd[0] = 1'b0;
        step();

        // BEQ taken, EX_LAT=3
        do_reset(1);
        op[1] = OP_BRANCH; bc[1] = 1'b1; ird[1] = 1'b1; rw_seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2) ird[1] = 1'b0;
            smp();
            rw_seen = rw_seen | rgw[1];
            chk($sformatf("beq_c%0d_pc_write", c), pcw[1], (c == 5));
            if (c >= 3 && c <= 5) chk($sformatf("beq_c%0d_state", c), st[1], S_EX);
            if (c == 6) chk("beq_c6_state", st[1], S_IF);
            step();
        end
        chk("beq_reg_write_never", rw_seen, 0);

        // ECALL without halt: 2 cycles
        do_reset(1);
        op[1] = OP_ECALL; ird[1] = 1'b1;
        smp(); step(); ird[1] = 1'b0;
        smp(); chk("ecall_c2_state_pc", {st[1], pcw[1]}, {S_ID, 1'b1});
        step(); smp(); chk("ecall_c3_state", st[1], S_IF);
        step();

        // TIMEOUT=0 disables the watchdog even across counter saturation
        do_reset(1);
        op[1] = OP_ADDI;
        repeat (300) step();
        smp(); chk("b_no_timeout_state_flag", {st[1], tmo[1]}, {S_IF, 1'b0});
        step();

        // ECALL halt, then 20 cycles of ready toggling must change nothing
        do_reset(0);
        op[0] = OP_ECALL; hl[0] = 1'b1; ird[0] = 1'b1;
        smp(); step(); ird[0] = 1'b0;
        smp(); chk("halt_c2_pc_write", pcw[0], 0);
        step(); smp(); chk("halt_c3_state_halted", {st[0], hal[0]}, {S_HALT, 1'b1});
        for (int c = 0; c < 20; c++) begin
            step();
            ird[0] = 1'($urandom);
            drd[0] = 1'($urandom);
            smp();
            chk($sformatf("halt_hold_%0d", c), act(0), {S_HALT, 6'b0, 1'b1, 1'b0});
        end
        step();

        // Fetch timeout, with an async reset mid-wait proving the counter restarts at 0
        do_reset(0);
        op[0] = OP_ADDI; hl[0] = 1'b0; ird[0] = 1'b0; drd[0] = 1'b0;
        repeat (6) step();
        #2 rn_a = 1'b0;
        #1 chk("a_async_reset_imem_req", {st[0], imr[0]}, {S_IF, 1'b0});
        step(); rn_a = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            smp();
            if (c <= 10) chk($sformatf("tmo_c%0d_state_flag", c), {st[0], tmo[0]}, {S_IF, 1'b0});
            else         chk("tmo_c11_halt_flags", {st[0], hal[0], tmo[0]}, {S_HALT, 2'b11});
            step();
        end

        // Ready on the last allowed wait cycle wins over the timeout
        do_reset(0);
        op[0] = OP_ADDI;
        for (int c = 1; c <= 10; c++) begin
            ird[0] = (c == 10);
            smp();
            if (c == 10) chk("tmo_edge_c10_ir_write", irw[0], 1);
            step();
        end
        ird[0] = 1'b0;
        smp(); chk("tmo_edge_c11_state_flag", {st[0], tmo[0]}, {S_ID, 1'b0});
        step();

        // Data-memory timeout on a LOAD that never completes
        do_reset(0);
        op[0] = OP_LOAD; ird[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) ird[0] = 1'b0;
            smp();
            if (c == 13) chk("mem_tmo_c13_state", {st[0], tmo[0]}, {S_MEM, 1'b0});
            if (c == 14) chk("mem_tmo_c14_state", {st[0], tmo[0]}, {S_HALT, 1'b1});
            step();
        end

        // Async reset during a STORE data wait
        do_reset(1);
        op[1] = OP_STORE; ird[1] = 1'b1;
        smp(); step(); ird[1] = 1'b0;
        repeat (4) step();
        smp(); chk("rst_mem_c6_req_we", {st[1], dmr[1], dwe[1]}, {S_MEM, 2'b11});
        step();
        #2 rn_b = 1'b0;
        #1 chk("rst_mem_async_drop", {st[1], dmr[1], dwe[1], pcw[1]}, {S_IF, 3'b000});
        step(); rn_b = 1'b1; ird[1] = 1'b1;
        smp(); chk("rst_mem_restart_req", {st[1], imr[1], irw[1]}, {S_IF, 2'b11});
        step(); ird[1] = 1'b0;
        smp(); chk("rst_mem_restart_id", st[1], S_ID);
        step();

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
